if_fetch: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch FIFO and drives the registered if_id outputs (inst, inst_addr, valid) into decode.
- Handles jump redirect (flush) from execute and hold (stall) from downstream.

---
 rtl/if_fetch.sv | 191 +++++++++++++++++++
 tb/tb_if_fetch.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: PC owner, imem req/gnt/rvalid master, prefetch FIFO, if_id output register.
// Optional IF_MISALIGN_TRAP_EN adds misalign_o, pulsed after a jump to a non-word target.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } fetch_ent_t;

  logic [31:0] pc_q, pc_d;
  logic        out_q, out_d;
  logic [31:0] out_addr_q, out_addr_d;
  logic        discard_q, discard_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  fetch_ent_t  mem_q [FIFO_DEPTH];
  fetch_ent_t  mem_d [FIFO_DEPTH];
  logic [31:0] inst_q, inst_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        valid_q, valid_d;

  logic        rv;
  logic        pop;
  logic        push;
  logic        req;
  logic        fire;
  logic [31:0] credit;
  fetch_ent_t  head;

  // Handshake control: credits count buffered, in-flight and leaving words
  always_comb begin
    rv     = imem_rvalid_i & out_q;
    pop    = !jump_en_i && !hold_i && (cnt_q != '0);
    credit = 32'(cnt_q) + {31'd0, out_q} - {31'd0, pop};
    req    = !rst && !jump_en_i
             && (credit < 32'(FIFO_DEPTH))
             && (!out_q || imem_rvalid_i);
    fire   = req && imem_gnt_i;
    push   = rv && !discard_q && !jump_en_i;
    head   = mem_q[rd_q];
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;

  // Next-state for PC, in-flight tracking and the prefetch FIFO
  always_comb begin
    pc_d       = pc_q;
    out_d      = out_q;
    out_addr_d = out_addr_q;
    discard_d  = discard_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    mem_d      = mem_q;
    if (rv) begin
      out_d     = 1'b0;
      discard_d = 1'b0;
    end
    if (fire) begin
      out_d      = 1'b1;
      out_addr_d = pc_q;
      pc_d       = pc_q + 32'd4;
    end
    if (push) begin
      mem_d[wr_q] = '{inst: imem_rdata_i, addr: out_addr_q};
      wr_d        = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (jump_en_i) begin
      pc_d      = jump_addr_i & ~32'h3;
      discard_d = out_q && !imem_rvalid_i;
      cnt_d     = '0;
      wr_d      = '0;
      rd_d      = '0;
    end
  end

  // if_id output register: jump beats hold beats advance
  always_comb begin
    inst_d  = inst_q;
    iaddr_d = iaddr_q;
    valid_d = valid_q;
    if (jump_en_i) begin
      inst_d  = NOP;
      iaddr_d = '0;
      valid_d = 1'b0;
    end else if (hold_i) begin
      inst_d  = inst_q;
    end else if (cnt_q != '0) begin
      inst_d  = head.inst;
      iaddr_d = head.addr;
      valid_d = 1'b1;
    end else begin
      inst_d  = NOP;
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_q      <= 1'b0;
      out_addr_q <= '0;
      discard_q  <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      inst_q     <= NOP;
      iaddr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      out_addr_q <= out_addr_d;
      discard_q  <= discard_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
      inst_q     <= inst_d;
      iaddr_q    <= iaddr_d;
      valid_q    <= valid_d;
    end
  end

  assign inst_o       = inst_q;
  assign inst_addr_o  = iaddr_q;
  assign inst_valid_o = valid_q;

  // A push into a full FIFO without a pop means the credit check is broken
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  // Flag a jump whose target had non-zero low bits
  always_comb begin
    misalign_d = jump_en_i && (jump_addr_i[1:0] != 2'b00);
  end

  // Misalign pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios for if_fetch with RESET_PC=0x100, FIFO_DEPTH=2.
// Memory grants when gnt is set and returns addr ^ 0xDEAD0000 one cycle later.
module tb_if_fetch;

  localparam logic [31:0] K   = 32'hDEAD_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        jump;
  logic [31:0] jaddr;
  logic        hold;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int vec = 0;
  int bad = 0;

  if_fetch #(
    .RESET_PC   (32'h0000_0100),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .jump_en_i     (jump),
    .jump_addr_i   (jaddr),
    .hold_i        (hold),
    .inst_o        (inst),
    .inst_addr_o   (inst_addr),
    .inst_valid_o  (inst_valid)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rvalid <= imem_req & gnt;
    imem_rdata  <= imem_addr ^ K;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    gnt   = 1'b1;
    jump  = 1'b0;
    hold  = 1'b0;
    jaddr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    rst   = 1'b1;
    gnt   = 1'b1;
    jump  = 1'b0;
    hold  = 1'b0;
    jaddr = '0;
    tick();
    vec++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL rst_req act=%b/%h exp=0/00000100", imem_req, imem_addr);
    end
    vec++;
    if (inst !== NOP || inst_addr !== 32'h0 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_out act=%h/%h/%b exp=%h/0/0", inst, inst_addr, inst_valid, NOP);
    end
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (inst_valid !== 1'b1 && n < 10);
    vec++;
    if (n != 3 || inst_addr !== 32'h100 || inst !== (32'h100 ^ K)) begin
      bad++;
      $display("FAIL first_fetch act=n%0d/%h/%h exp=n3/00000100/%h", n, inst_addr, inst, 32'h100 ^ K);
    end
    for (int i = 1; i <= 2; i++) begin
      tick();
      vec++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h100 + 32'(4 * i) || inst !== ((32'h100 + 32'(4 * i)) ^ K)) begin
        bad++;
        $display("FAIL stream%0d act=%b/%h/%h exp=1/%h", i, inst_valid, inst_addr, inst, 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_gnt_stall;
    int n;
    do_reset();
    tick();
    gnt = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
        bad++;
        $display("FAIL stall_req%0d act=%b/%h exp=1/00000104", i, imem_req, imem_addr);
      end
      tick();
      if (i == 1) begin
        vec++;
        if (inst_valid !== 1'b1 || inst_addr !== 32'h100) begin
          bad++;
          $display("FAIL stall_drain act=%b/%h exp=1/00000100", inst_valid, inst_addr);
        end
      end
    end
    vec++;
    if (inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'h100 || imem_addr !== 32'h104) begin
      bad++;
      $display("FAIL stall_empty act=%b/%h/%h/%h exp=0/%h/00000100/00000104", inst_valid, inst, inst_addr, imem_addr, NOP);
    end
    gnt = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (inst_valid !== 1'b1 && n < 10);
    vec++;
    if (n != 3 || inst_addr !== 32'h104 || inst !== (32'h104 ^ K)) begin
      bad++;
      $display("FAIL stall_resume act=n%0d/%h/%h exp=n3/00000104", n, inst_addr, inst);
    end
  endtask

  task automatic test_hold;
    logic [31:0] e;
    do_reset();
    repeat (4) tick();
    vec++;
    if (inst_valid !== 1'b1 || inst_addr !== 32'h104) begin
      bad++;
      $display("FAIL hold_pre act=%b/%h exp=1/00000104", inst_valid, inst_addr);
    end
    hold = 1'b1;
    #1;
    vec++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL hold_credit act=%b exp=0", imem_req);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++;
      if (inst_valid !== 1'b1 || inst_addr !== 32'h104 || inst !== (32'h104 ^ K) || imem_req !== 1'b0) begin
        bad++;
        $display("FAIL hold_frz%0d act=%b/%h/%h/req%b exp=1/00000104/%h/req0", i, inst_valid, inst_addr, inst, imem_req, 32'h104 ^ K);
      end
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = 32'h108 + 32'(4 * i);
      vec++;
      if (inst_valid !== 1'b1 || inst_addr !== e || inst !== (e ^ K)) begin
        bad++;
        $display("FAIL hold_rel%0d act=%b/%h/%h exp=1/%h/%h", i, inst_valid, inst_addr, inst, e, e ^ K);
      end
    end
  endtask

  task automatic test_jump;
    int n;
    do_reset();
    repeat (4) tick();
    jump  = 1'b1;
    jaddr = 32'h200;
    hold  = 1'b1;
    #1;
    vec++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL jump_req act=%b exp=0", imem_req);
    end
    tick();
    jump = 1'b0;
    hold = 1'b0;
    vec++;
    if (inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'h0) begin
      bad++;
      $display("FAIL jump_out act=%b/%h/%h exp=0/%h/0", inst_valid, inst, inst_addr, NOP);
    end
`ifdef IF_MISALIGN_TRAP_EN
    vec++;
    if (misalign !== 1'b0) begin
      bad++;
      $display("FAIL jump_mis act=%b exp=0", misalign);
    end
`endif
    #1;
    vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++;
      $display("FAIL jump_target act=%b/%h exp=1/00000200", imem_req, imem_addr);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (inst_valid !== 1'b1 && n < 10);
    vec++;
    if (n != 3 || inst_addr !== 32'h200 || inst !== (32'h200 ^ K)) begin
      bad++;
      $display("FAIL jump_first act=n%0d/%h/%h exp=n3/00000200", n, inst_addr, inst);
    end
    tick();
    vec++;
    if (inst_valid !== 1'b1 || inst_addr !== 32'h204) begin
      bad++;
      $display("FAIL jump_next act=%b/%h exp=1/00000204", inst_valid, inst_addr);
    end
  endtask

  task automatic test_wrap;
    int n;
    do_reset();
    tick();
    jump  = 1'b1;
    jaddr = 32'hFFFF_FFFC;
    tick();
    jump = 1'b0;
    #1;
    vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_top act=%b/%h exp=1/fffffffc", imem_req, imem_addr);
    end
    tick();
    vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_zero act=%b/%h exp=1/00000000", imem_req, imem_addr);
    end
    n = 0;
    while (inst_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    vec++;
    if (inst_addr !== 32'hFFFF_FFFC || inst !== (32'hFFFF_FFFC ^ K)) begin
      bad++;
      $display("FAIL wrap_out0 act=%b/%h/%h exp=1/fffffffc", inst_valid, inst_addr, inst);
    end
    tick();
    vec++;
    if (inst_valid !== 1'b1 || inst_addr !== 32'h0 || inst !== K) begin
      bad++;
      $display("FAIL wrap_out1 act=%b/%h/%h exp=1/00000000/%h", inst_valid, inst_addr, inst, K);
    end
  endtask

  task automatic test_reset_midop;
    int n;
    do_reset();
    repeat (4) tick();
    rst = 1'b1;
    #1;
    vec++;
    if (inst_valid !== 1'b0 || inst !== NOP || inst_addr !== 32'h0 || imem_req !== 1'b0 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL midrst act=%b/%h/%h/%b/%h exp=0/%h/0/0/00000100", inst_valid, inst, inst_addr, imem_req, imem_addr, NOP);
    end
    rst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (inst_valid !== 1'b1 && n < 10);
    vec++;
    if (n != 3 || inst_addr !== 32'h100 || inst !== (32'h100 ^ K)) begin
      bad++;
      $display("FAIL midrst_late act=n%0d/%h/%h exp=n3/00000100", n, inst_addr, inst);
    end
  endtask

`ifdef IF_MISALIGN_TRAP_EN
  task automatic test_misalign;
    int n;
    do_reset();
    tick();
    jump  = 1'b1;
    jaddr = 32'h203;
    tick();
    jump = 1'b0;
    #1;
    vec++;
    if (misalign !== 1'b1 || imem_addr !== 32'h200) begin
      bad++;
      $display("FAIL mis_pulse act=%b/%h exp=1/00000200", misalign, imem_addr);
    end
    tick();
    vec++;
    if (misalign !== 1'b0) begin
      bad++;
      $display("FAIL mis_clear act=%b exp=0", misalign);
    end
    n = 0;
    while (inst_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    vec++;
    if (inst_valid !== 1'b1 || inst_addr !== 32'h200) begin
      bad++;
      $display("FAIL mis_fetch act=%b/%h exp=1/00000200", inst_valid, inst_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_gnt_stall();
    test_hold();
    test_jump();
    test_wrap();
    test_reset_midop();
`ifdef IF_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
